// File: rtl/snake_pkg.sv
// Shared playfield geometry, coordinate widths and the apple spawn state encoding.
// Imported by the apple spawn controller and by the wall/bounds logic.
package snake_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int APPLE_SIZE = 10;
    localparam int BORDER     = 10;
    localparam int X_W        = 10;
    localparam int Y_W        = 9;
    localparam int SCORE_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_BOUNDS,
        ST_QUERY,
        ST_PLACED
    } spawn_state_e;

    // Score counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/apple_spawn_ctrl_if.sv
// Signal bundle between the apple spawn controller, the random generator,
// the snake body checker and the apple renderer.
interface apple_spawn_ctrl_if;
    import snake_pkg::*;

    logic               start;
    logic               good_collision;
    logic [X_W-1:0]     rand_X;
    logic [Y_W-1:0]     rand_Y;
    logic               rand_next;
    logic               check_req;
    logic [X_W-1:0]     check_x;
    logic [Y_W-1:0]     check_y;
    logic               check_ack;
    logic               check_hit;
    logic [X_W-1:0]     appleX;
    logic [Y_W-1:0]     appleY;
    logic               apple_valid;
    logic               eaten;
    logic [SCORE_W-1:0] score;

    modport master (
        input  start, good_collision, rand_X, rand_Y, check_ack, check_hit,
        output rand_next, check_req, check_x, check_y,
               appleX, appleY, apple_valid, eaten, score
    );

    modport slave (
        output start, good_collision, rand_X, rand_Y, check_ack, check_hit,
        input  rand_next, check_req, check_x, check_y,
               appleX, appleY, apple_valid, eaten, score
    );

endinterface

// File: rtl/apple_bounds_chk.sv
// Combinational test that an apple-sized square at (x, y) lies fully inside the walls.
// Sums are widened to 11 bits so coordinates near the top of range cannot wrap.
module apple_bounds_chk
    import snake_pkg::*;
(
    input  logic [X_W-1:0] x_i,
    input  logic [Y_W-1:0] y_i,
    output logic           in_bounds_o
);

    logic [10:0] x_end;
    logic [10:0] y_end;

    assign x_end = {1'b0, x_i} + 11'(APPLE_SIZE);
    assign y_end = {2'b00, y_i} + 11'(APPLE_SIZE);

    assign in_bounds_o = (x_i >= X_W'(BORDER))
                      && (x_end <= 11'(SCREEN_W - BORDER))
                      && (y_i >= Y_W'(BORDER))
                      && (y_end <= 11'(SCREEN_H - BORDER));

endmodule

// File: rtl/apple_spawn_ctrl.sv
// Apple placement sequencer: samples random candidates, rejects wall/body overlaps,
// falls back to a fixed spot after repeated rejects, and counts apples eaten.
module apple_spawn_ctrl
    import snake_pkg::*;
#(
    parameter int MAX_RETRY  = 15,
    parameter int FALLBACK_X = 320,
    parameter int FALLBACK_Y = 240
) (
    input  logic               VGA_clk,
    input  logic               reset,
    apple_spawn_ctrl_if.master spawn_if
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    spawn_state_e       state_q, state_d;
    logic               start_hist_q, coll_hist_q;
    logic [X_W-1:0]     cand_x_q, cand_x_d;
    logic [Y_W-1:0]     cand_y_q, cand_y_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [X_W-1:0]     apple_x_q, apple_x_d;
    logic [Y_W-1:0]     apple_y_q, apple_y_d;
    logic               apple_valid_q, apple_valid_d;
    logic               rand_next_q, rand_next_d;
    logic               check_req_q, check_req_d;
    logic [X_W-1:0]     check_x_q, check_x_d;
    logic [Y_W-1:0]     check_y_q, check_y_d;
    logic               eaten_q, eaten_d;
    logic [SCORE_W-1:0] score_q, score_d;

    logic               start_rise, coll_rise, cand_in_bounds;
    logic               reject, commit;
    logic [X_W-1:0]     commit_x;
    logic [Y_W-1:0]     commit_y;

    apple_bounds_chk u_bounds (
        .x_i        (cand_x_q),
        .y_i        (cand_y_q),
        .in_bounds_o(cand_in_bounds)
    );

    assign start_rise = spawn_if.start & ~start_hist_q;
    assign coll_rise  = spawn_if.good_collision & ~coll_hist_q;

    always_comb begin
        state_d       = state_q;
        cand_x_d      = cand_x_q;
        cand_y_d      = cand_y_q;
        retry_d       = retry_q;
        apple_x_d     = apple_x_q;
        apple_y_d     = apple_y_q;
        apple_valid_d = apple_valid_q;
        rand_next_d   = 1'b0;
        check_req_d   = check_req_q;
        check_x_d     = check_x_q;
        check_y_d     = check_y_q;
        eaten_d       = 1'b0;
        score_d       = score_q;
        reject        = 1'b0;
        commit        = 1'b0;
        commit_x      = cand_x_q;
        commit_y      = cand_y_q;

        if (!spawn_if.start) begin
            // Game stopped: abandon any query, keep score and last apple position.
            state_d       = ST_IDLE;
            check_req_d   = 1'b0;
            apple_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    apple_valid_d = 1'b0;
                    if (start_rise) begin
                        score_d = '0;
                        retry_d = '0;
                        state_d = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    rand_next_d = 1'b1;
                    cand_x_d    = spawn_if.rand_X;
                    cand_y_d    = spawn_if.rand_Y;
                    state_d     = ST_BOUNDS;
                end
                ST_BOUNDS: begin
                    if (cand_in_bounds) begin
                        check_req_d = 1'b1;
                        check_x_d   = cand_x_q;
                        check_y_d   = cand_y_q;
                        state_d     = ST_QUERY;
                    end else begin
                        reject = 1'b1;
                    end
                end
                ST_QUERY: begin
                    if (spawn_if.check_ack) begin
                        check_req_d = 1'b0;
                        if (spawn_if.check_hit) begin
                            reject = 1'b1;
                        end else begin
                            commit = 1'b1;
                        end
                    end
                end
                ST_PLACED: begin
                    if (coll_rise) begin
                        eaten_d       = 1'b1;
                        score_d       = sat_inc(score_q);
                        apple_valid_d = 1'b0;
                        state_d       = ST_SAMPLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // The reject that reaches the limit commits the fixed spot unchecked.
            if (reject) begin
                if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
                    commit   = 1'b1;
                    commit_x = X_W'(FALLBACK_X);
                    commit_y = Y_W'(FALLBACK_Y);
                end else begin
                    retry_d = retry_q + 1'b1;
                    state_d = ST_SAMPLE;
                end
            end

            if (commit) begin
                apple_x_d     = commit_x;
                apple_y_d     = commit_y;
                apple_valid_d = 1'b1;
                retry_d       = '0;
                state_d       = ST_PLACED;
            end
        end
    end

    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            start_hist_q  <= 1'b0;
            coll_hist_q   <= 1'b0;
            cand_x_q      <= '0;
            cand_y_q      <= '0;
            retry_q       <= '0;
            apple_x_q     <= X_W'(FALLBACK_X);
            apple_y_q     <= Y_W'(FALLBACK_Y);
            apple_valid_q <= 1'b0;
            rand_next_q   <= 1'b0;
            check_req_q   <= 1'b0;
            check_x_q     <= '0;
            check_y_q     <= '0;
            eaten_q       <= 1'b0;
            score_q       <= '0;
        end else begin
            state_q       <= state_d;
            start_hist_q  <= spawn_if.start;
            coll_hist_q   <= spawn_if.good_collision;
            cand_x_q      <= cand_x_d;
            cand_y_q      <= cand_y_d;
            retry_q       <= retry_d;
            apple_x_q     <= apple_x_d;
            apple_y_q     <= apple_y_d;
            apple_valid_q <= apple_valid_d;
            rand_next_q   <= rand_next_d;
            check_req_q   <= check_req_d;
            check_x_q     <= check_x_d;
            check_y_q     <= check_y_d;
            eaten_q       <= eaten_d;
            score_q       <= score_d;
        end
    end

    assign spawn_if.rand_next   = rand_next_q;
    assign spawn_if.check_req   = check_req_q;
    assign spawn_if.check_x     = check_x_q;
    assign spawn_if.check_y     = check_y_q;
    assign spawn_if.appleX      = apple_x_q;
    assign spawn_if.appleY      = apple_y_q;
    assign spawn_if.apple_valid = apple_valid_q;
    assign spawn_if.eaten       = eaten_q;
    assign spawn_if.score       = score_q;

endmodule

// File: doc/apple_spawn_ctrl.md
# apple_spawn_ctrl

Sequences apple placement for the snake game. Draws candidate coordinates from the random generator, rejects those outside the playfield border or on the snake body (queried through a request/acknowledge port to the snake logic), and commits accepted positions to the apple renderer. Also detects apple-eaten events and keeps the score. Sits between `random_apple`, the snake body logic and the apple drawing logic, all on `VGA_clk`.

## Interface
- `SCREEN_W`, 640, horizontal active pixels
- `SCREEN_H`, 480, vertical active pixels
- `APPLE_SIZE`, 10, apple edge length in pixels
- `BORDER`, 10, wall thickness; the apple must lie fully inside it
- `MAX_RETRY`, 15, number of rejected candidates before fallback
- `FALLBACK_X`, 320, fallback apple X
- `FALLBACK_Y`, 240, fallback apple Y
- `SCORE_W`, 8, score width

- `VGA_clk`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  game running (level)
- `good_collision`  in  1  snake head overlaps apple (level)
- `rand_X`  in  10  random X candidate
- `rand_Y`  in  9  random Y candidate
- `rand_next`  out  1  one-cycle pulse asking the generator to advance
- `check_req`  out  1  body-overlap query valid
- `check_x`  out  10  query X
- `check_y`  out  9  query Y
- `check_ack`  in  1  query answered (one-cycle pulse)
- `check_hit`  in  1  candidate overlaps body; valid only with `check_ack`
- `appleX`  out  10  committed apple X
- `appleY`  out  9  committed apple Y
- `apple_valid`  out  1  apple may be drawn and eaten
- `eaten`  out  1  one-cycle pulse per eat event
- `score`  out  `SCORE_W`  apples eaten this game

## Operation
- States: IDLE, SAMPLE, BOUNDS, QUERY, PLACED.
- IDLE: `apple_valid`=0. On a rising edge of `start`: clear `score`, clear the retry count, go to SAMPLE.
- SAMPLE: pulse `rand_next`, register `rand_X`/`rand_Y` into the candidate, go to BOUNDS.
- BOUNDS: the candidate is in bounds iff X ≥ `BORDER`, X+`APPLE_SIZE` ≤ `SCREEN_W`−`BORDER`, Y ≥ `BORDER`, and Y+`APPLE_SIZE` ≤ `SCREEN_H`−`BORDER`. Evaluate the sums at 11 bits so they cannot wrap. If the candidate is in bounds, go to QUERY; otherwise it is a reject.
- QUERY: assert `check_req` with `check_x`/`check_y` equal to the candidate. Hold all three stable until the cycle `check_ack`=1, then deassert the next cycle. `check_hit`=1 is a reject; `check_hit`=0 commits the candidate.
- Reject: increment the retry count. If the count reaches `MAX_RETRY`, commit `FALLBACK_X`/`FALLBACK_Y` without checking them. Otherwise go to SAMPLE.
- Commit: load `appleX`/`appleY`, set `apple_valid`=1, clear the retry count, go to PLACED.
- PLACED: on a rising edge of `good_collision`:
  - pulse `eaten`;
  - increment `score`, saturating at all-ones;
  - clear `apple_valid`;
  - go to SAMPLE.
- In states other than PLACED, `good_collision` edges are ignored. No eat event and no score increment occur there.
- `start` low in any state forces IDLE next cycle and drops `check_req`. An outstanding `check_ack` is then ignored. `score` and `appleX`/`appleY` hold.

## Timing
- Reset values:
  - state IDLE;
  - `appleX` = `FALLBACK_X`, `appleY` = `FALLBACK_Y`;
  - `apple_valid`, `rand_next`, `check_req`, `eaten` = 0;
  - `score` = 0;
  - `check_x`/`check_y` = 0;
  - edge-detect registers = 0.
- Reset asserted mid-query drops `check_req` immediately (asynchronous).
- All outputs are registered.
- Out-of-bounds reject: SAMPLE→BOUNDS→SAMPLE, a 2-cycle loop.
- Best-case placement: start or eat edge → `apple_valid` high after 3 cycles + query latency.
  - Path: SAMPLE, BOUNDS, QUERY(ack), commit.
  - With `check_ack` in the first QUERY cycle, this totals 4 cycles.
- `eaten` is high in the cycle after the `good_collision` edge is registered. `apple_valid` falls in the same cycle.
- Edge detection uses a one-flop history. A collision held high for many cycles produces exactly one eat.
- Worst case before fallback: `MAX_RETRY` rejects.

## Structure
- Shared package `snake_pkg`: screen dimensions, `BORDER`, `APPLE_SIZE`, coordinate widths (X 10, Y 9), state encoding.
- One sub-module, `apple_bounds_chk`: a combinational in-bounds test, reused by snake wall-collision logic.

## Test plan
- Reset, then `start` rises, `rand_X`=100, `rand_Y`=50, `check_ack`=1/`check_hit`=0 on the first query → `appleX`=100, `appleY`=50, `apple_valid`=1 four cycles after `start`; `score`=0.
- `rand_X`=635 → rejected at BOUNDS with no `check_req`; next sample `rand_X`=200, `rand_Y`=200 accepted → `appleX`=200.
- `check_hit`=1 on every query → fallback commit after 15 rejects: `appleX`=320, `appleY`=240.
- In PLACED, `good_collision` held high for 20 cycles → exactly one `eaten` pulse and `score`=1; a new apple is committed.
- `score` at 255 plus one eat → `score` stays 255 and `eaten` still pulses.
- `reset` asserted while `check_req`=1 → `check_req`=0 asynchronously, state IDLE, outputs at reset values; a late `check_ack` has no effect.
